// File: rtl/line_memory_lat.sv
// line_memory_lat: line-granular backing memory with a valid/ready request
// channel, an in-order request FIFO and a fixed per-access service latency.
// Optional build macro: LINE_MEMORY_BYTE_MASK_EN adds req_wstrb byte-enable
// writes; without it every write replaces the full line.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | nothing in service; pops the FIFO head when one is present
// BUSY  | down-counting the access latency; access happens at cnt == 0
// RESP  | response presented and held until resp_ready
module line_memory_lat #(
    parameter int LINE_BITS   = 128,
    parameter int DEPTH       = 1024,
    parameter int ADDR_BITS   = 32,
    parameter int LATENCY     = 10,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_BITS-1:0]   req_addr,
    input  logic [LINE_BITS-1:0]   req_wdata,
`ifdef LINE_MEMORY_BYTE_MASK_EN
    input  logic [LINE_BITS/8-1:0] req_wstrb,
`endif
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic                   resp_write,
    output logic [LINE_BITS-1:0]   resp_rdata
);

    localparam int STRB_BITS = LINE_BITS / 8;
    localparam int OFF       = $clog2(STRB_BITS);
    localparam int IDX_BITS  = $clog2(DEPTH);
    localparam int QB        = $clog2(QUEUE_DEPTH);
    localparam int CNT_BITS  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    logic [LINE_BITS-1:0] memArray [0:DEPTH-1];

    logic                 q_write [QUEUE_DEPTH];
    logic [IDX_BITS-1:0]  q_idx   [QUEUE_DEPTH];
    logic [LINE_BITS-1:0] q_wdata [QUEUE_DEPTH];
    logic [STRB_BITS-1:0] q_wstrb [QUEUE_DEPTH];
    logic [QB-1:0]        wr_ptr, rd_ptr;
    logic [QB:0]          fifo_cnt;

    state_t               state, state_next;
    logic [CNT_BITS-1:0]  cnt;
    logic                 svc_write;
    logic [IDX_BITS-1:0]  svc_idx;
    logic [LINE_BITS-1:0] svc_wdata;
    logic [STRB_BITS-1:0] svc_wstrb;

    logic                 push, pop, access, fifo_empty;
    logic [STRB_BITS-1:0] req_strb;

`ifdef LINE_MEMORY_BYTE_MASK_EN
    assign req_strb = req_wstrb;
`else
    // Without byte masking a write is simply an all-bytes-enabled write.
    assign req_strb = '1;
`endif

    // Readiness looks only at occupancy, so a full FIFO refuses even when a pop is due.
    assign req_ready  = (fifo_cnt != (QB+1)'(QUEUE_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign push       = req_valid && req_ready;

    // FIFO payload storage; data slots need no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            q_write[wr_ptr] <= req_write;
            q_idx[wr_ptr]   <= req_addr[OFF +: IDX_BITS];
            q_wdata[wr_ptr] <= req_wdata;
            q_wstrb[wr_ptr] <= req_strb;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and pop/access strobes.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        access     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    access     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = BUSY;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Service register, latency down-counter and response outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt        <= '0;
            svc_write  <= 1'b0;
            svc_idx    <= '0;
            svc_wdata  <= '0;
            svc_wstrb  <= '0;
            resp_valid <= 1'b0;
            resp_write <= 1'b0;
            resp_rdata <= '0;
        end else begin
            if (pop) begin
                svc_write <= q_write[rd_ptr];
                svc_idx   <= q_idx[rd_ptr];
                svc_wdata <= q_wdata[rd_ptr];
                svc_wstrb <= q_wstrb[rd_ptr];
                cnt       <= CNT_BITS'(LATENCY - 1);
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (access) begin
                resp_valid <= 1'b1;
                resp_write <= svc_write;
                resp_rdata <= svc_write ? '0 : memArray[svc_idx];
            end else if (state == RESP && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

    // Line storage; never reset so preloaded contents survive, and a write
    // only commits on its access cycle, so reset before that cancels it.
    always_ff @(posedge clock) begin
        if (reset && access && svc_write) begin
            for (int b = 0; b < STRB_BITS; b++) begin
                if (svc_wstrb[b]) memArray[svc_idx][8*b +: 8] <= svc_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: doc/line_memory_lat.md
Name: line_memory_lat

Overview:
- Parametrised line-granular backing memory, the successor to the fixed 128-bit main memory behind the mem stage.
- Adds a valid/ready request channel, a queue of outstanding requests, and a configurable fixed access latency, so cache miss/refill timing is realistic.
- Requests are served strictly in order.
- Storage array stays named memArray[0:DEPTH-1], LINE_BITS wide, so benches can keep backdoor preload.

Parameters:
- LINE_BITS, 128, line width in bits (multiple of 32, power of two).
- DEPTH, 1024, number of lines (power of two).
- ADDR_BITS, 32, byte-address width.
- LATENCY, 10, service cycles per access (>=1).
- QUEUE_DEPTH, 4, request FIFO entries (power of two, >=2).

Ports:
- clock  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-low (0 = reset).
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept.
- req_write  in  1  1 = write line, 0 = read line.
- req_addr  in  ADDR_BITS  byte address.
- req_wdata  in  LINE_BITS  write line data.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_write  out  1  response is a write acknowledge.
- resp_rdata  out  LINE_BITS  read data (0 for write acks).

Behaviour:
- Accept: on a posedge with req_valid && req_ready, push {write, index, wdata} into the FIFO.
- req_ready = !fifo_full. It depends only on the occupancy count; a same-cycle dequeue does not admit a push when full.
- Line index = req_addr[OFF +: log2(DEPTH)], where OFF = log2(LINE_BITS/8).
  - Low offset bits are ignored (no misalignment error).
  - Upper bits are ignored, so addresses wrap modulo DEPTH lines.
- FSM states: IDLE, BUSY, RESP.
  - IDLE: if FIFO non-empty at a posedge, pop the head into the service register, load cnt = LATENCY-1, go to BUSY. An entry pushed at edge T is popped no earlier than edge T+1.
  - BUSY: at each posedge, if cnt == 0, perform the access and go to RESP; otherwise decrement cnt.
  - Access on a read: resp_rdata <= memArray[idx].
  - Access on a write: memArray[idx] <= wdata; resp_rdata <= 0.
  - On entering RESP: resp_valid <= 1 and resp_write <= op.
  - RESP: outputs are held stable while resp_ready = 0. On a posedge with resp_ready = 1, if the FIFO is non-empty, pop directly into BUSY (back-to-back); otherwise go to IDLE with resp_valid <= 0.
- Latency:
  - Request accepted at edge T with the FSM idle and FIFO empty: resp_valid is high after edge T+1+LATENCY.
  - Back-to-back requests: response spacing is LATENCY+1 cycles with resp_ready tied high.
- Ordering: accesses commit in acceptance order, so a read after a write to the same line returns the new data.
- Reset (reset = 0 at a posedge):
  - FIFO emptied, FSM to IDLE, cnt = 0, resp_valid = 0, resp_write = 0, resp_rdata = 0; req_ready reads 1 once reset is released.
  - memArray is NOT cleared, so preload survives.
  - Reset mid-operation drops all queued and in-service requests. An in-service write that has not yet reached cnt == 0 is not committed.
- Simultaneous events:
  - Push and pop in the same cycle keeps the count unchanged.
  - Push while in RESP is allowed when the FIFO is not full.

Optional Feature:
- Macro: LINE_MEMORY_BYTE_MASK_EN.
- Defined:
  - Adds port req_wstrb (in, LINE_BITS/8), stored in the FIFO with the request.
  - A write updates only bytes whose strobe bit is 1; other bytes keep their old value.
  - A read ignores req_wstrb.
  - A write with all-zero strobe still returns an ack and leaves the line unchanged.
- Undefined: the port is absent and writes replace the full line.

Test Plan:
- Reset: hold reset = 0 for 2 cycles, then release -> resp_valid = 0, resp_rdata = 0, req_ready = 1; memArray[0] preloaded as {3,2,1,0} is unchanged.
- Single read, LATENCY = 10: read addr 0x10 accepted at edge T -> resp_valid rises after edge T+11 with resp_rdata = {7,6,5,4}, resp_write = 0.
- Write then read:
  - Write 0x20 with data 128'hDEAD_BEEF, then read 0x20 back-to-back -> write ack with resp_rdata = 0, then read returns 128'hDEAD_BEEF.
  - Responses are LATENCY+1 cycles apart.
- Full queue:
  - Hold resp_ready = 0 and issue 6 reads -> req_ready drops after 4 are queued plus 1 in service.
  - The 6th read is held until the first response is consumed; all 6 responses arrive in order with correct data.
  - Response data stays stable throughout the backpressure.
- Wrap: read addr DEPTH*16 (0x4000) -> returns memArray[0]. Read addr 0x13 -> returns memArray[1].
- Mid-operation reset: write 0x30 accepted, reset asserted 3 cycles later -> no response; a subsequent read of 0x30 returns the preload value.
- With LINE_MEMORY_BYTE_MASK_EN defined: write 0x00 with data all-FF and wstrb 16'h000F -> reads back {3,2,1,32'hFFFFFFFF}.
